// File: rtl/fib_pkg.sv
// Shared types and helpers for the longest-prefix-match FIB table.
// Entry fields are sized to upper bounds; instances zero-extend their narrower fields.
package fib_pkg;

  localparam int MAX_PREFIX_W = 128;
  localparam int MAX_LEN_W    = 8;
  localparam int MAX_FACE_W   = 8;
  localparam int MAX_AGE_W    = 8;

  typedef struct packed {
    logic                    valid;
    logic [MAX_PREFIX_W-1:0] prefix;
    logic [MAX_LEN_W-1:0]    len;
    logic [MAX_FACE_W-1:0]   face;
    logic [MAX_AGE_W-1:0]    age;
  } fib_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } fib_state_t;

  // Sets the top 'len' bits of a 'width'-bit MSB-aligned field held in bits [width-1:0].
  function automatic logic [MAX_PREFIX_W-1:0] len_mask(input logic [MAX_LEN_W-1:0] len,
                                                        input int width);
    logic [MAX_PREFIX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PREFIX_W; i++) begin
      if (i < width && i >= width - int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fib_prefix_match.sv
// Compares one stored entry against a (masked, clamped) key.
// match: entry covers the key; exact: same length and same masked prefix.
module fib_prefix_match
  import fib_pkg::*;
#(
  parameter int PREFIX_W = 64
) (
  input  fib_entry_t entry,
  input  fib_entry_t key,
  output logic       match,
  output logic       exact
);

  logic [MAX_PREFIX_W-1:0] mask;
  logic                    unused_fields;

  assign mask  = len_mask(entry.len, PREFIX_W);
  assign match = entry.valid && (entry.len <= key.len) &&
                 (((entry.prefix ^ key.prefix) & mask) == '0);
  assign exact = entry.valid && (entry.len == key.len) && (entry.prefix == key.prefix);

  assign unused_fields = ^{entry.face, entry.age, key.valid, key.face, key.age};

endmodule

// File: rtl/fib_lpm_table.sv
// DEPTH-entry prefix->face table with serial longest-prefix-match lookup and install/refresh.
// Build option FIB_LRU_EN: LRU eviction by per-entry age; otherwise round-robin eviction.
module fib_lpm_table
  import fib_pkg::*;
#(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 7,
  parameter int DEPTH    = 8,
  parameter int FACE_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  output logic                lookup_ready,
  input  logic [PREFIX_W-1:0] lookup_prefix,
  input  logic [LEN_W-1:0]    lookup_len,
  output logic                result_valid,
  output logic                result_hit,
  output logic [FACE_W-1:0]   result_face,
  output logic [LEN_W-1:0]    result_len,
  input  logic                insert_valid,
  input  logic [PREFIX_W-1:0] insert_prefix,
  input  logic [LEN_W-1:0]    insert_len,
  input  logic [FACE_W-1:0]   insert_face,
  output logic                insert_done,
  output logic [LEN_W-1:0]    entry_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PREFIX_W);

  fib_state_t          state_reg;
  fib_entry_t          table_reg [DEPTH];
  fib_entry_t          key_reg;
  logic                op_insert_reg;
  logic [IDX_W-1:0]    idx_reg;

  logic                best_hit_reg;
  logic [IDX_W-1:0]    best_idx_reg;
  logic [MAX_LEN_W-1:0] best_len_reg;
  logic [MAX_FACE_W-1:0] best_face_reg;
  logic                exact_found_reg;
  logic [IDX_W-1:0]    exact_idx_reg;
  logic                free_found_reg;
  logic [IDX_W-1:0]    free_idx_reg;

  logic                lookup_ready_reg;
  logic                result_valid_reg;
  logic                result_hit_reg;
  logic [FACE_W-1:0]   result_face_reg;
  logic [LEN_W-1:0]    result_len_reg;
  logic                insert_done_reg;
  logic [LEN_W-1:0]    count_reg;

  assign lookup_ready = lookup_ready_reg;
  assign result_valid = result_valid_reg;
  assign result_hit   = result_hit_reg;
  assign result_face  = result_face_reg;
  assign result_len   = result_len_reg;
  assign insert_done  = insert_done_reg;
  assign entry_count  = count_reg;

  // Request capture: insert wins over a simultaneous lookup; lengths clamp to PREFIX_W.
  logic [LEN_W-1:0] req_len_raw;
  logic [LEN_W-1:0] req_len;
  fib_entry_t       req_key;

  always_comb begin
    req_len_raw    = insert_valid ? insert_len : lookup_len;
    req_len        = (req_len_raw > LEN_MAX) ? LEN_MAX : req_len_raw;
    req_key        = '0;
    req_key.valid  = 1'b1;
    req_key.len    = MAX_LEN_W'(req_len);
    req_key.prefix = MAX_PREFIX_W'(insert_valid ? insert_prefix : lookup_prefix) &
                     len_mask(MAX_LEN_W'(req_len), PREFIX_W);
    req_key.face   = insert_valid ? MAX_FACE_W'(insert_face) : '0;
  end

  fib_entry_t scan_entry;
  logic       scan_match;
  logic       scan_exact;

  assign scan_entry = table_reg[idx_reg];

  fib_prefix_match #(
    .PREFIX_W(PREFIX_W)
  ) u_match (
    .entry(scan_entry),
    .key  (key_reg),
    .match(scan_match),
    .exact(scan_exact)
  );

  logic [IDX_W-1:0] victim_idx;
  logic [IDX_W-1:0] write_idx;
  logic             write_is_free;
  logic             write_is_evict;

  assign write_is_free  = !exact_found_reg && free_found_reg;
  assign write_is_evict = !exact_found_reg && !free_found_reg;
  assign write_idx      = exact_found_reg ? exact_idx_reg :
                          free_found_reg  ? free_idx_reg  : victim_idx;

`ifdef FIB_LRU_EN
  localparam int AGE_W = $clog2(DEPTH);

  logic             touch_en;
  logic [IDX_W-1:0] touch_idx;
  logic [AGE_W-1:0] touch_age;
  logic [AGE_W-1:0] victim_age;
  logic [DEPTH-1:0] age_inc;

  // A fresh slot behaves as if it were the oldest, so every valid entry ages by one.
  always_comb begin
    touch_en  = 1'b0;
    touch_idx = best_idx_reg;
    touch_age = '0;
    if (state_reg == RESP && best_hit_reg) begin
      touch_en  = 1'b1;
      touch_age = table_reg[best_idx_reg].age[AGE_W-1:0];
    end else if (state_reg == WRITE) begin
      touch_en  = 1'b1;
      touch_idx = write_idx;
      touch_age = write_is_free ? AGE_W'(DEPTH-1) : table_reg[write_idx].age[AGE_W-1:0];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    assign age_inc[gi] = touch_en && table_reg[gi].valid && (IDX_W'(gi) != touch_idx) &&
                         (table_reg[gi].age[AGE_W-1:0] < touch_age);
  end

  always_comb begin
    victim_idx = '0;
    victim_age = table_reg[0].age[AGE_W-1:0];
    for (int i = 1; i < DEPTH; i++) begin
      if (table_reg[i].age[AGE_W-1:0] > victim_age) begin
        victim_age = table_reg[i].age[AGE_W-1:0];
        victim_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_reg;

  assign victim_idx = rr_ptr_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      for (int i = 0; i < DEPTH; i++) table_reg[i] <= '0;
      key_reg          <= '0;
      op_insert_reg    <= 1'b0;
      idx_reg          <= '0;
      best_hit_reg     <= 1'b0;
      best_idx_reg     <= '0;
      best_len_reg     <= '0;
      best_face_reg    <= '0;
      exact_found_reg  <= 1'b0;
      exact_idx_reg    <= '0;
      free_found_reg   <= 1'b0;
      free_idx_reg     <= '0;
      lookup_ready_reg <= 1'b1;
      result_valid_reg <= 1'b0;
      result_hit_reg   <= 1'b0;
      result_face_reg  <= '0;
      result_len_reg   <= '0;
      insert_done_reg  <= 1'b0;
      count_reg        <= '0;
`ifndef FIB_LRU_EN
      rr_ptr_reg       <= '0;
`endif
    end else begin
      result_valid_reg <= 1'b0;
      insert_done_reg  <= 1'b0;
`ifdef FIB_LRU_EN
      for (int i = 0; i < DEPTH; i++) begin
        if (age_inc[i]) table_reg[i].age <= table_reg[i].age + MAX_AGE_W'(1);
      end
`endif
      case (state_reg)
        IDLE: begin
          if (insert_valid || lookup_valid) begin
            key_reg          <= req_key;
            op_insert_reg    <= insert_valid;
            idx_reg          <= '0;
            best_hit_reg     <= 1'b0;
            best_idx_reg     <= '0;
            best_len_reg     <= '0;
            best_face_reg    <= '0;
            exact_found_reg  <= 1'b0;
            free_found_reg   <= 1'b0;
            lookup_ready_reg <= 1'b0;
            state_reg        <= SCAN;
          end
        end
        SCAN: begin
          if (op_insert_reg) begin
            if (scan_exact && !exact_found_reg) begin
              exact_found_reg <= 1'b1;
              exact_idx_reg   <= idx_reg;
            end
            if (!scan_entry.valid && !free_found_reg) begin
              free_found_reg <= 1'b1;
              free_idx_reg   <= idx_reg;
            end
          end else if (scan_match && (!best_hit_reg || scan_entry.len > best_len_reg)) begin
            // Strictly longer only, so equal-length ties keep the lower index.
            best_hit_reg  <= 1'b1;
            best_idx_reg  <= idx_reg;
            best_len_reg  <= scan_entry.len;
            best_face_reg <= scan_entry.face;
          end
          if (idx_reg == IDX_W'(DEPTH-1)) begin
            state_reg <= op_insert_reg ? WRITE : RESP;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        RESP: begin
          result_valid_reg <= 1'b1;
          result_hit_reg   <= best_hit_reg;
          result_face_reg  <= FACE_W'(best_face_reg);
          result_len_reg   <= LEN_W'(best_len_reg);
`ifdef FIB_LRU_EN
          if (best_hit_reg) table_reg[best_idx_reg].age <= '0;
`endif
          lookup_ready_reg <= 1'b1;
          state_reg        <= IDLE;
        end
        WRITE: begin
          table_reg[write_idx] <= key_reg;
          if (write_is_free) count_reg <= count_reg + LEN_W'(1);
`ifndef FIB_LRU_EN
          if (write_is_evict) begin
            rr_ptr_reg <= (rr_ptr_reg == IDX_W'(DEPTH-1)) ? '0 : rr_ptr_reg + IDX_W'(1);
          end
`endif
          insert_done_reg  <= 1'b1;
          lookup_ready_reg <= 1'b1;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_lpm_table.sv
// Directed bench for fib_lpm_table (DEPTH=8); eviction expectations follow FIB_LRU_EN.
module tb_fib_lpm_table;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 7;
  localparam int DEPTH    = 8;
  localparam int FACE_W   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                lookup_valid = 1'b0;
  logic                lookup_ready;
  logic [PREFIX_W-1:0] lookup_prefix = '0;
  logic [LEN_W-1:0]    lookup_len = '0;
  logic                result_valid;
  logic                result_hit;
  logic [FACE_W-1:0]   result_face;
  logic [LEN_W-1:0]    result_len;
  logic                insert_valid = 1'b0;
  logic [PREFIX_W-1:0] insert_prefix = '0;
  logic [LEN_W-1:0]    insert_len = '0;
  logic [FACE_W-1:0]   insert_face = '0;
  logic                insert_done;
  logic [LEN_W-1:0]    entry_count;

  int checks   = 0;
  int failures = 0;

  fib_lpm_table #(
    .PREFIX_W(PREFIX_W),
    .LEN_W   (LEN_W),
    .DEPTH   (DEPTH),
    .FACE_W  (FACE_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_ready (lookup_ready),
    .lookup_prefix(lookup_prefix),
    .lookup_len   (lookup_len),
    .result_valid (result_valid),
    .result_hit   (result_hit),
    .result_face  (result_face),
    .result_len   (result_len),
    .insert_valid (insert_valid),
    .insert_prefix(insert_prefix),
    .insert_len   (insert_len),
    .insert_face  (insert_face),
    .insert_done  (insert_done),
    .entry_count  (entry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic lookup_check(input string tag, input logic [63:0] p, input logic [6:0] l,
                              input logic exp_hit, input logic [1:0] exp_face,
                              input logic [6:0] exp_len);
    int lat;
    lookup_prefix = p;
    lookup_len    = l;
    lookup_valid  = 1'b1;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = n;
        break;
      end
    end
    $display("lookup %s %h/%0d -> hit=%0b face=%0d len=%0d latency=%0d",
             tag, p, l, result_hit, result_face, result_len, lat);
    check({tag, "_latency"}, 64'(lat), 64'(DEPTH + 1));
    check({tag, "_hit"}, 64'(result_hit), 64'(exp_hit));
    check({tag, "_face"}, 64'(result_face), 64'(exp_face));
    check({tag, "_len"}, 64'(result_len), 64'(exp_len));
  endtask

  task automatic insert_check(input string tag, input logic [63:0] p, input logic [6:0] l,
                              input logic [1:0] f);
    int lat;
    insert_prefix = p;
    insert_len    = l;
    insert_face   = f;
    insert_valid  = 1'b1;
    @(posedge clk); #1;
    insert_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (insert_done) begin
        lat = n;
        break;
      end
    end
    $display("insert %s %h/%0d face=%0d -> latency=%0d count=%0d", tag, p, l, f, lat, entry_count);
    check({tag, "_latency"}, 64'(lat), 64'(DEPTH + 1));
  endtask

  initial begin
    int ins_cyc;
    int res_cyc;
    int pulses;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(lookup_ready), 64'd1);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_hit", 64'(result_hit), 64'd0);
    check("rst_face", 64'(result_face), 64'd0);
    check("rst_len", 64'(result_len), 64'd0);
    check("rst_done", 64'(insert_done), 64'd0);
    check("rst_count", 64'(entry_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    lookup_check("empty", 64'h0000FFFF0000FFFF, 7'd64, 1'b0, 2'd0, 7'd0);

    insert_check("ins_a", 64'h0000FFFF00000000, 7'd32, 2'd1);
    insert_check("ins_b", 64'h0000FF0000000000, 7'd16, 2'd2);
    check("count_2", 64'(entry_count), 64'd2);
    lookup_check("lpm_a", 64'h0000FFFF0000FFFF, 7'd64, 1'b1, 2'd1, 7'd32);
    lookup_check("lpm_b", 64'h0000FF1200000000, 7'd64, 1'b1, 2'd2, 7'd16);

    insert_check("ins_dflt", 64'h0, 7'd0, 2'd3);
    lookup_check("dflt", 64'hDEAD000000000000, 7'd64, 1'b1, 2'd3, 7'd0);
    check("count_3", 64'(entry_count), 64'd3);

    insert_check("refresh_a", 64'h0000FFFF00000000, 7'd32, 2'd0);
    check("count_refresh", 64'(entry_count), 64'd3);
    lookup_check("refreshed", 64'h0000FFFF0000FFFF, 7'd64, 1'b1, 2'd0, 7'd32);
    lookup_check("clamp", 64'h0000FFFF0000FFFF, 7'd127, 1'b1, 2'd0, 7'd32);
    lookup_check("short_key", 64'h0000FFFF0000FFFF, 7'd20, 1'b1, 2'd2, 7'd16);

    // Fill slots 3..7.
    for (int i = 3; i < DEPTH; i++) begin
      logic [63:0] p;
      p = {16'hA000 + 16'(i), 48'h0};
      insert_check("fill", p, 7'd16, 2'(i));
    end
    check("count_full", 64'(entry_count), 64'(DEPTH));

    insert_check("evict_x", 64'hBEEF000000000000, 7'd16, 2'd1);
    check("count_evict_x", 64'(entry_count), 64'(DEPTH));
    lookup_check("x_present", 64'hBEEF123400000000, 7'd64, 1'b1, 2'd1, 7'd16);
`ifdef FIB_LRU_EN
    lookup_check("dflt_evicted", 64'hDEAD000000000000, 7'd64, 1'b0, 2'd0, 7'd0);
`else
    lookup_check("dflt_kept", 64'hDEAD000000000000, 7'd64, 1'b1, 2'd3, 7'd0);
`endif
    insert_check("evict_y", 64'hCAFE000000000000, 7'd16, 2'd2);
    check("count_evict_y", 64'(entry_count), 64'(DEPTH));
`ifdef FIB_LRU_EN
    lookup_check("after_y", 64'h0000FFFF0000FFFF, 7'd64, 1'b1, 2'd2, 7'd16);
`else
    lookup_check("after_y", 64'h0000FFFF0000FFFF, 7'd64, 1'b1, 2'd3, 7'd0);
`endif
    lookup_check("y_present", 64'hCAFE000000000000, 7'd64, 1'b1, 2'd2, 7'd16);

    // Simultaneous requests: insert first, held lookup afterwards.
    insert_prefix = 64'h1234000000000000;
    insert_len    = 7'd16;
    insert_face   = 2'd1;
    insert_valid  = 1'b1;
    lookup_prefix = 64'hCAFE000000000000;
    lookup_len    = 7'd64;
    lookup_valid  = 1'b1;
    @(posedge clk); #1;
    insert_valid = 1'b0;
    ins_cyc = 0;
    res_cyc = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (ins_cyc != 0 && n == ins_cyc + 1) lookup_valid = 1'b0;
      if (insert_done && ins_cyc == 0) ins_cyc = n;
      if (result_valid) begin
        res_cyc = n;
        break;
      end
    end
    lookup_valid = 1'b0;
    $display("both insert_done@%0d result_valid@%0d hit=%0b face=%0d len=%0d",
             ins_cyc, res_cyc, result_hit, result_face, result_len);
    check("prio_insert_cycle", 64'(ins_cyc), 64'(DEPTH + 1));
    check("prio_result_cycle", 64'(res_cyc), 64'(2 * DEPTH + 3));
    check("prio_face", 64'(result_face), 64'd2);
    check("prio_len", 64'(result_len), 64'd16);

    // Reset during SCAN of an insert.
    insert_prefix = 64'h5555000000000000;
    insert_len    = 7'd16;
    insert_face   = 2'd1;
    insert_valid  = 1'b1;
    @(posedge clk); #1;
    insert_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("scan_ready_low", 64'(lookup_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    check("abort_ready", 64'(lookup_ready), 64'd1);
    for (int n = 0; n < 15; n++) begin
      if (insert_done || result_valid) pulses++;
      @(posedge clk); #1;
    end
    $display("reset_abort pulses=%0d count=%0d", pulses, entry_count);
    check("abort_pulses", 64'(pulses), 64'd0);
    check("abort_count", 64'(entry_count), 64'd0);
    lookup_check("abort_nowrite", 64'h5555000000000000, 7'd64, 1'b0, 2'd0, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
